// File: rtl/mux_tree_pipe_pkg.sv
// Shared helpers for the pipelined mux tree: select width, latency and
// the mask of which tree levels carry a pipeline register.
package mux_tree_pipe_pkg;

  // Widest tree the registered-level mask can describe (levels 1..MASK_W).
  localparam int MASK_W = 32;

  // Ceiling log2, never below 1 so a 2:1 tree still has one select bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Number of register stages a sample crosses from input to output.
  function automatic int calc_lat(input int levels, input int reg_every);
    return ((levels - 1) / reg_every) + 1;
  endfunction

  // Bit k-1 set when level k ends in a register; the last level always does.
  function automatic logic [MASK_W-1:0] reg_level_mask(input int levels,
                                                       input int reg_every);
    logic [MASK_W-1:0] m;
    m = '0;
    for (int k = 1; k <= MASK_W; k++) begin
      if ((k <= levels) && (((k % reg_every) == 0) || (k == levels))) begin
        m[k-1] = 1'b1;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/mux_tree_pipe_if.sv
// Bus bundle for the pipelined mux tree.
//
// Handshake: a sample (din, sel, in_valid) is accepted on every rising edge
// where en=1; with en=0 the whole pipe freezes and the presented sample is
// dropped. There is no ready: the consumer takes dout/sel_err on every edge
// where en=1 and out_valid=1. in_valid=0 still moves data, only unqualified.
interface mux_tree_pipe_if
  import mux_tree_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_IN  = 8
);
  localparam int SEL_W = clog2(N_IN);

  logic                  en;
  logic                  in_valid;
  logic [SEL_W-1:0]      sel;
  logic [N_IN*WIDTH-1:0] din;
  logic                  out_valid;
  logic [WIDTH-1:0]      dout;
  logic                  sel_err;

  modport master (
    output en, in_valid, sel, din,
    input  out_valid, dout, sel_err
  );

  modport slave (
    input  en, in_valid, sel, din,
    output out_valid, dout, sel_err
  );

endinterface

// File: rtl/mux_tree_pipe_level.sv
// One level of the mux tree: N_NODES 2:1 muxes steered by bit 0 of the
// residual select, optionally followed by a register that also carries
// the remaining select bits, the valid flag and the error flag.
module mux_level_pipe
  import mux_tree_pipe_pkg::*;
#(
  parameter int N_NODES    = 1,
  parameter int WIDTH      = 8,
  parameter int SEL_W      = 1,
  parameter int REGISTERED = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [2*N_NODES*WIDTH-1:0]   data_i,
  input  logic [SEL_W-1:0]             sel_i,
  input  logic                         valid_i,
  input  logic                         err_i,
  output logic [N_NODES*WIDTH-1:0]     data_o,
  output logic [SEL_W-1:0]             sel_o,
  output logic                         valid_o,
  output logic                         err_o
);

  logic [N_NODES*WIDTH-1:0] data_c;
  logic [SEL_W-1:0]         sel_c;

  // Pick the odd child of each pair when this level's select bit is set,
  // then drop that bit so the next level sees its own bit at position 0.
  always_comb begin
    data_c = '0;
    for (int j = 0; j < N_NODES; j++) begin
      data_c[j*WIDTH +: WIDTH] = sel_i[0] ? data_i[(2*j+1)*WIDTH +: WIDTH]
                                          : data_i[(2*j)*WIDTH +: WIDTH];
    end
    sel_c = sel_i >> 1;
  end

  if (REGISTERED != 0) begin : g_reg
    logic [N_NODES*WIDTH-1:0] data_q;
    logic [SEL_W-1:0]         sel_q;
    logic                     valid_q;
    logic                     err_q;

    // Stage register: reset clears everything, en=0 freezes everything.
    always_ff @(posedge clk) begin
      if (rst) begin
        data_q  <= '0;
        sel_q   <= '0;
        valid_q <= 1'b0;
        err_q   <= 1'b0;
      end else if (en) begin
        data_q  <= data_c;
        sel_q   <= sel_c;
        valid_q <= valid_i;
        err_q   <= err_i;
      end
    end

    assign data_o  = data_q;
    assign sel_o   = sel_q;
    assign valid_o = valid_q;
    assign err_o   = err_q;
  end else begin : g_comb
    // Pass-through level: the next registered level does the holding.
    logic unused_ctrl;
    assign unused_ctrl = clk ^ rst ^ en;

    assign data_o  = data_c;
    assign sel_o   = sel_c;
    assign valid_o = valid_i;
    assign err_o   = err_i;
  end

endmodule

// File: rtl/mux_tree_pipe.sv
// Parametrised N_IN:1 selector built as a binary tree of 2:1 levels with
// pipeline registers between levels. Each stage carries its own copy of
// the select, so the live sel only steers level 1.
module mux_tree_pipe
  import mux_tree_pipe_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int N_IN      = 8,
  parameter int REG_EVERY = 1
) (
  input logic            clk,
  input logic            rst,
  mux_tree_pipe_if.slave bus
);

  localparam int              SEL_W    = clog2(N_IN);
  localparam int              L        = SEL_W;
  localparam int              N_LEAF   = 2 ** L;
  localparam int              N_NODE   = 2 * N_LEAF - 1;
  localparam int              PAD      = N_LEAF - N_IN;
  localparam logic [MASK_W-1:0] REG_MASK = reg_level_mask(L, REG_EVERY);

  // All tree nodes laid out level by level: leaves first (N_LEAF nodes),
  // then level 1 (N_LEAF/2), ... and the root last.
  wire [N_NODE*WIDTH-1:0]  tree_data;
  wire [(L+1)*SEL_W-1:0]   sel_chain;
  wire [L:0]               valid_chain;
  wire [L:0]               err_chain;
  wire [N_LEAF*WIDTH-1:0]  leaves;
  logic                    in_err;
  logic                    unused_sel_tail;

  // Out-of-range select is decided once at the input and travels with data.
  assign in_err = ({1'b0, bus.sel} >= (SEL_W+1)'(N_IN));

  // Missing channels read as zero.
  if (PAD > 0) begin : g_pad
    assign leaves = {{(PAD*WIDTH){1'b0}}, bus.din};
  end else begin : g_nopad
    assign leaves = bus.din;
  end

  // Blanking the leaves of an erroneous sample makes every node of its
  // path zero, so dout is zero without any logic after the last register.
  assign tree_data[N_LEAF*WIDTH-1:0] = in_err ? '0 : leaves;
  assign sel_chain[SEL_W-1:0]        = bus.sel;
  assign valid_chain[0]              = bus.in_valid;
  assign err_chain[0]                = in_err;

  for (genvar k = 1; k <= L; k++) begin : g_lvl
    localparam int NK    = 2 ** (L - k);
    localparam int OFF_I = 2 * N_LEAF - 2 ** (L - k + 2);
    localparam int OFF_O = 2 * N_LEAF - 2 ** (L - k + 1);

    mux_level_pipe #(
      .N_NODES    (NK),
      .WIDTH      (WIDTH),
      .SEL_W      (SEL_W),
      .REGISTERED (int'(REG_MASK[k-1]))
    ) u_level (
      .clk     (clk),
      .rst     (rst),
      .en      (bus.en),
      .data_i  (tree_data[OFF_I*WIDTH +: 2*NK*WIDTH]),
      .sel_i   (sel_chain[(k-1)*SEL_W +: SEL_W]),
      .valid_i (valid_chain[k-1]),
      .err_i   (err_chain[k-1]),
      .data_o  (tree_data[OFF_O*WIDTH +: NK*WIDTH]),
      .sel_o   (sel_chain[k*SEL_W +: SEL_W]),
      .valid_o (valid_chain[k]),
      .err_o   (err_chain[k])
    );
  end

  // Every select bit is consumed by the root, so the tail is always zero.
  assign unused_sel_tail = ^sel_chain[L*SEL_W +: SEL_W];

  // The last level is always registered: outputs come straight from flops.
  assign bus.dout      = tree_data[(N_NODE-1)*WIDTH +: WIDTH];
  assign bus.out_valid = valid_chain[L];
  assign bus.sel_err   = err_chain[L];

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Bench for mux_tree_pipe: four configurations side by side, a delay-line
// model of "channel picked LAT accepted edges ago", and directed literals.
module tb_mux_tree_pipe;
  import mux_tree_pipe_pkg::*;

  // Configurations: a=defaults, b=N_IN 5, c=REG_EVERY 2, d=N_IN 2 WIDTH 16
  localparam int N_IN_T [4] = '{8, 5, 8, 2};
  localparam int W_T    [4] = '{8, 8, 8, 16};
  localparam int LAT_T  [4] = '{3, 3, 2, 1};
  localparam int SELW_T [4] = '{3, 3, 3, 1};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- stimulus and observation ----------------
  logic        en_v   [4];
  logic        iv_v   [4];
  logic [2:0]  sel_v  [4];
  logic [63:0] din_v  [4];
  logic        ov     [4];
  logic        err_v  [4];
  logic [15:0] dout_v [4];
  logic        chk_on;

  int n_checks = 0;
  int n_fail   = 0;

  mux_tree_pipe_if #(.WIDTH(8),  .N_IN(8)) if_a ();
  mux_tree_pipe_if #(.WIDTH(8),  .N_IN(5)) if_b ();
  mux_tree_pipe_if #(.WIDTH(8),  .N_IN(8)) if_c ();
  mux_tree_pipe_if #(.WIDTH(16), .N_IN(2)) if_d ();

  mux_tree_pipe #(.WIDTH(8),  .N_IN(8), .REG_EVERY(1)) u_a (.clk(clk), .rst(rst), .bus(if_a));
  mux_tree_pipe #(.WIDTH(8),  .N_IN(5), .REG_EVERY(1)) u_b (.clk(clk), .rst(rst), .bus(if_b));
  mux_tree_pipe #(.WIDTH(8),  .N_IN(8), .REG_EVERY(2)) u_c (.clk(clk), .rst(rst), .bus(if_c));
  mux_tree_pipe #(.WIDTH(16), .N_IN(2), .REG_EVERY(1)) u_d (.clk(clk), .rst(rst), .bus(if_d));

  assign if_a.en = en_v[0];  assign if_a.in_valid = iv_v[0];
  assign if_a.sel = sel_v[0]; assign if_a.din = din_v[0];
  assign if_b.en = en_v[1];  assign if_b.in_valid = iv_v[1];
  assign if_b.sel = sel_v[1]; assign if_b.din = din_v[1][39:0];
  assign if_c.en = en_v[2];  assign if_c.in_valid = iv_v[2];
  assign if_c.sel = sel_v[2]; assign if_c.din = din_v[2];
  assign if_d.en = en_v[3];  assign if_d.in_valid = iv_v[3];
  assign if_d.sel = sel_v[3][0]; assign if_d.din = din_v[3][31:0];

  assign ov[0] = if_a.out_valid; assign err_v[0] = if_a.sel_err; assign dout_v[0] = {8'h00, if_a.dout};
  assign ov[1] = if_b.out_valid; assign err_v[1] = if_b.sel_err; assign dout_v[1] = {8'h00, if_b.dout};
  assign ov[2] = if_c.out_valid; assign err_v[2] = if_c.sel_err; assign dout_v[2] = {8'h00, if_c.dout};
  assign ov[3] = if_d.out_valid; assign err_v[3] = if_d.sel_err; assign dout_v[3] = if_d.dout;

  // ---------------- model ----------------
  // Entry = {valid, err, data}. mdl[d][0] is what the outputs must show;
  // the newest accepted sample sits at mdl[d][LAT-1].
  logic [33:0] mdl [4][3];

  function automatic logic [33:0] model_entry(input int d, input logic iv,
                                              input logic [2:0] sel,
                                              input logic [63:0] din);
    int          s;
    logic        err;
    logic [63:0] wmask;
    logic [31:0] data;
    s     = int'(sel) & ((1 << SELW_T[d]) - 1);
    err   = (s >= N_IN_T[d]);
    wmask = (64'd1 << W_T[d]) - 64'd1;
    data  = '0;
    if (!err) data = 32'((din >> (s * W_T[d])) & wmask);
    return {iv, err, data};
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 4; d++) begin
      if (rst) begin
        for (int s = 0; s < 3; s++) mdl[d][s] <= '0;
      end else if (en_v[d]) begin
        for (int s = 0; s < 2; s++) begin
          if (s < LAT_T[d] - 1) mdl[d][s] <= mdl[d][s+1];
        end
        mdl[d][LAT_T[d]-1] <= model_entry(d, iv_v[d], sel_v[d], din_v[d]);
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_out(input int d, input string tag, input logic ovx,
                         input logic errx, input logic [15:0] dx);
    check($sformatf("%s dut%0d out_valid", tag, d), 64'(ov[d]),     64'(ovx));
    check($sformatf("%s dut%0d sel_err", tag, d),   64'(err_v[d]),  64'(errx));
    check($sformatf("%s dut%0d dout", tag, d),      64'(dout_v[d]), 64'(dx));
  endtask

  // Model-vs-DUT on every cycle once reset has been applied.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int d = 0; d < 4; d++) begin
        check($sformatf("model dut%0d out_valid", d), 64'(ov[d]),     64'(mdl[d][0][33]));
        check($sformatf("model dut%0d sel_err", d),   64'(err_v[d]),  64'(mdl[d][0][32]));
        check($sformatf("model dut%0d dout", d),      64'(dout_v[d]), 64'(mdl[d][0][15:0]));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  logic [2:0] pat_sel [5] = '{3'd5, 3'd2, 3'd7, 3'd0, 3'd3};
  logic [7:0] pat_exp [5] = '{8'h36, 8'h33, 8'h38, 8'h31, 8'h34};

  initial begin
    chk_on = 1'b0;
    rst    = 1'b1;
    for (int d = 0; d < 4; d++) begin
      en_v[d]  = 1'b1;
      iv_v[d]  = 1'b0;
      sel_v[d] = 3'd0;
    end
    din_v[0] = 64'h1716_1514_1312_1110;
    din_v[1] = 64'h0000_00A4_A3A2_A1A0;
    din_v[2] = 64'h3837_3635_3433_3231;
    din_v[3] = 64'h0000_0000_BEEF_1234;

    repeat (2) @(negedge clk);
    chk_on = 1'b1;
    exp_out(0, "reset", 1'b0, 1'b0, 16'h0);
    exp_out(3, "reset", 1'b0, 1'b0, 16'h0);
    rst = 1'b0;

    // Sweep on a, range errors on b, travelling select on c, 2:1 on d.
    for (int t = 0; t < 12; t++) begin
      if (t >= 3 && t <= 10) exp_out(0, "sweep", 1'b1, 1'b0, 16'(32'h10 + t - 3));
      if (t == 5) check("model pin sweep", 64'(mdl[0][0][15:0]), 64'h12);
      if (t == 3) exp_out(1, "range sel6", 1'b1, 1'b1, 16'h0);
      if (t == 4) exp_out(1, "range sel4", 1'b1, 1'b0, 16'h00A4);
      if (t == 5) exp_out(1, "range sel7", 1'b1, 1'b1, 16'h0);
      if (t == 6) exp_out(1, "range idle", 1'b0, 1'b0, 16'h00A0);
      if (t >= 2 && t <= 6) exp_out(2, "travel", 1'b1, 1'b0, {8'h00, pat_exp[t-2]});
      if (t == 1) exp_out(3, "two sel1", 1'b1, 1'b0, 16'hBEEF);
      if (t == 2) exp_out(3, "two idle", 1'b0, 1'b0, 16'h1234);

      iv_v[0]  = (t < 8);
      sel_v[0] = (t < 8) ? 3'(t) : 3'd0;
      iv_v[1]  = (t < 3);
      sel_v[1] = (t == 0) ? 3'd6 : (t == 1) ? 3'd4 : (t == 2) ? 3'd7 : 3'd0;
      iv_v[2]  = (t < 5);
      sel_v[2] = (t < 5) ? pat_sel[t] : 3'd0;
      iv_v[3]  = (t == 0);
      sel_v[3] = (t == 0) ? 3'd1 : 3'd0;
      @(negedge clk);
    end

    // Stall on a: samples 0,1,2 then four frozen cycles with junk offered.
    for (int s = 0; s < 12; s++) begin
      if (s >= 3 && s <= 7) exp_out(0, "stall hold", 1'b1, 1'b0, 16'h0010);
      if (s == 8)  exp_out(0, "stall s1", 1'b1, 1'b0, 16'h0011);
      if (s == 9)  exp_out(0, "stall s2", 1'b1, 1'b0, 16'h0012);
      if (s == 10) exp_out(0, "stall after", 1'b0, 1'b0, 16'h0015);

      if (s < 3) begin
        en_v[0] = 1'b1; iv_v[0] = 1'b1; sel_v[0] = 3'(s);
      end else if (s < 7) begin
        en_v[0] = 1'b0; iv_v[0] = 1'b1; sel_v[0] = 3'd7;
      end else begin
        en_v[0] = 1'b1; iv_v[0] = 1'b0; sel_v[0] = 3'd5;
      end
      @(negedge clk);
    end

    // Reset mid-stream with two samples in flight (en=0 must not block it).
    for (int r = 0; r < 9; r++) begin
      if (r >= 3 && r <= 5) exp_out(0, "flush", 1'b0, 1'b0, 16'h0);
      if (r == 6) exp_out(0, "post reset", 1'b1, 1'b0, 16'h0016);
      if (r == 7) exp_out(0, "post idle", 1'b0, 1'b0, 16'h0010);

      rst = (r == 2);
      en_v[0] = (r != 2);
      iv_v[0] = (r == 0) || (r == 1) || (r == 3);
      sel_v[0] = (r == 0) ? 3'd3 : (r == 1) ? 3'd4 : (r == 3) ? 3'd6 : 3'd0;
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_tree_pipe.md
Name: mux_tree_pipe

Overview:
Parametrised N:1 multiplexer built as a binary tree of 2:1 levels, with pipeline registers between levels, a valid flag, a stall enable and an out-of-range select flag. Generalises the team's fixed 4:1 tree of 2:1 muxes in width, input count and pipelining. It is the datapath selector for wide buses where a single combinational tree would not close timing.

Parameters:
WIDTH, 8, data bits per input channel
N_IN, 8, number of input channels (>=2; need not be a power of two)
REG_EVERY, 1, register after every REG_EVERY-th tree level; the last level is always registered
SEL_W, clog2(N_IN), select width (derived; not to be overridden)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
en  in  1  pipeline advance; 0 = every stage holds its contents
in_valid  in  1  sample qualifier for din/sel
sel  in  SEL_W  channel index, LSB selects at level 1
din  in  N_IN*WIDTH  flattened inputs; channel i = din[i*WIDTH +: WIDTH]
out_valid  out  1  dout/sel_err qualified
dout  out  WIDTH  selected channel, delayed by LAT cycles
sel_err  out  1  sampled sel was >= N_IN

Behaviour:
- Levels L = SEL_W. Level k (1..L) pairs the level k-1 nodes and picks the odd node when sel bit k-1 = 1. Bit 0 drives level 1 (leaf pairs); bit L-1 drives the final 2:1.
- Leaves i in N_IN..2^L-1 read as zero.
- Registered levels are k where k mod REG_EVERY == 0 or k == L.
- LAT = floor((L-1)/REG_EVERY)+1. Defaults give L=3 and LAT=3.
- Each registered stage carries its node data, the remaining unused sel bits, a valid bit and an err bit. Later levels therefore use the select that travelled with the data, never the live sel.
- sel_err is computed at the input as (sel >= N_IN). When sel_err=1, dout = 0 regardless of tree contents.
- en=1: every stage loads from its predecessor on the clock edge. in_valid=0 still propagates data, but the valid bit is 0.
- en=0: all stages, including the valid, err and sel bits, hold. Input samples presented while en=0 are dropped.
- rst=1 at an edge: all stage registers, valid, err and sel bits go to 0. This gives out_valid=0, dout=0 and sel_err=0 on the following cycle and while rst stays high. rst overrides en.
- Reset mid-stream discards all in-flight samples. The first valid output after reset release comes LAT edges after the first accepted in_valid.
- Throughput is one sample per cycle while en=1. There is no backpressure beyond en.
- dout, out_valid and sel_err are driven directly from flops; there is no combinational path from inputs to outputs.
- N_IN=2 degenerates to L=1 and LAT=1.

Decomposition:
- Shared package/header: clog2 function, a LAT computation function, and a localparam for the registered-level mask.
- One sub-module, mux_level_pipe. It is one tree level: parameters are node count, WIDTH and REGISTERED (0/1). It carries data, residual sel, valid and err.
- mux_tree_pipe generates L instances of mux_level_pipe and the zero padding.

Test Plan:
- Defaults: din channel i = 8'h10+i, in_valid=1, sel swept 0..7 on consecutive cycles -> dout = 8'h10..8'h17 on cycles 3..10, with out_valid=1 and sel_err=0.
- N_IN=5: sel=3'd6, in_valid=1 -> after 3 cycles dout=0, sel_err=1, out_valid=1. sel=3'd4 -> dout = channel 4, sel_err=0.
- Stall: stream sel=0,1,2 with en=1, then en=0 for 4 cycles, then en=1 -> outputs hold their values during the stall. Samples 0,1,2 emerge in order with no loss or duplication. Samples driven during the stall do not appear.
- Reset mid-stream: 2 valid samples in flight, rst=1 for 1 cycle -> out_valid=0 and dout=0 the next cycle. Neither sample ever appears. A new sample after release appears after 3 cycles.
- REG_EVERY=2, N_IN=8: LAT=2. Changing sel every cycle with din fixed -> each output matches the sel sampled 2 cycles earlier, confirming sel travels with the data.
- N_IN=2, WIDTH=16: din={16'hBEEF,16'h1234}, sel=1 -> dout=16'hBEEF one cycle later. in_valid=0 -> out_valid=0.
